// File: rtl/uart_pkg.sv
// Shared types and frame constants for the RN41 8N1 UART.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Tick divider rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rn41_if.sv
// Parallel-side handshake between the UART and the wireless protocol block.
interface uart_rn41_if;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       is_transmitting;
    logic       recv_error;

    modport master (
        output transmit, tx_byte,
        input  received, rx_byte, is_receiving, is_transmitting, recv_error
    );

    modport slave (
        input  transmit, tx_byte,
        output received, rx_byte, is_receiving, is_transmitting, recv_error
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter, one-cycle tick at terminal count every DIV clks.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear || cnt_q == '0) cnt_d = RELOAD;
    end

    assign tick = (cnt_q == '0) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RELOAD;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rn41.sv
// 8N1 full-duplex UART for the RN41 serial link; independent RX and TX FSMs.
// Build option UART_RX_MAJORITY_EN: 3-sample majority vote on every RX bit.
//   state    | meaning
//   RX_IDLE  | waiting for falling edge on synced rx
//   RX_START | validating start bit at its centre
//   RX_DATA  | shifting in 8 data bits, LSB first
//   RX_STOP  | checking stop bit; good byte or framing error
//   RX_BREAK | after framing error, waiting for line high
//   TX_IDLE  | line high, accepting transmit
//   TX_START | driving start bit
//   TX_DATA  | driving data bits, LSB first
//   TX_STOP  | driving stop bit(s)
module uart_rn41
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    uart_rn41_if.slave bus
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int PW  = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PH_M1   = PW'(OVERSAMPLE / 2 - 2);
    localparam logic [PW-1:0] PH_M0   = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [3:0] RX_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] TX_LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0] TX_LAST_BIT  = 4'(DATA_BITS + STOP_BITS);

    logic [1:0] sync_q, vld_q;
    logic       rx_prev_q, rx_s;

    // rx_prev stays low until the synchroniser has flushed its reset value,
    // so a line that is low at reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            vld_q     <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            vld_q     <= {vld_q[0], 1'b1};
            rx_prev_q <= rx_s & vld_q[1];
        end
    end
    assign rx_s = sync_q[1];

    logic rx_tick, rx_clear, tx_tick, tx_clear;

    uart_baud_tick #(.DIV(DIV)) u_rx_tick (.clk(clk), .rst_n(rst_n), .clear(rx_clear), .tick(rx_tick));
    uart_baud_tick #(.DIV(DIV)) u_tx_tick (.clk(clk), .rst_n(rst_n), .clear(tx_clear), .tick(tx_tick));

    rx_state_t     rx_state_q, rx_state_d;
    logic [PW-1:0] rx_ph_q, rx_ph_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic          received_q, received_d, recv_error_q, recv_error_d, is_rx_q;
    logic          rx_val, rx_sample;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [PW-1:0] PH_DEC = PW'(OVERSAMPLE / 2);
    logic [1:0] maj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_q <= 2'b11;
        end else if (rx_tick) begin
            if (rx_ph_q == PH_M1) maj_q[0] <= rx_s;
            if (rx_ph_q == PH_M0) maj_q[1] <= rx_s;
        end
    end
    assign rx_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
    localparam logic [PW-1:0] PH_DEC = PH_M0;
    assign rx_val = rx_s;
`endif

    assign rx_sample = rx_tick && (rx_ph_q == PH_DEC);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_ph_d      = rx_tick ? rx_ph_q + 1'b1 : rx_ph_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        received_d   = 1'b0;
        recv_error_d = 1'b0;
        rx_clear     = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = RX_START;
                rx_ph_d    = '0;
                rx_clear   = 1'b1;
            end
            RX_START: if (rx_sample) begin
                if (rx_val) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: if (rx_sample) begin
                rx_shift_d = {rx_val, rx_shift_q[7:1]};
                if (rx_bit_q == RX_LAST_DATA) rx_state_d = RX_STOP;
                else                          rx_bit_d   = rx_bit_q + 1'b1;
            end
            RX_STOP: if (rx_sample) begin
                if (rx_val) begin
                    rx_byte_d  = rx_shift_q;
                    received_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    recv_error_d = 1'b1;
                    rx_state_d   = RX_BREAK;
                end
            end
            RX_BREAK: if (rx_s) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= RX_IDLE;
            rx_ph_q      <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
            is_rx_q      <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_ph_q      <= rx_ph_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            received_q   <= received_d;
            recv_error_q <= recv_error_d;
            is_rx_q      <= (rx_state_d != RX_IDLE);
        end
    end

    tx_state_t     tx_state_q, tx_state_d;
    logic [PW-1:0] tx_ph_q, tx_ph_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d, is_tx_q, tx_bit_end;

    assign tx_bit_end = tx_tick && (tx_ph_q == PH_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_ph_d    = tx_tick ? tx_ph_q + 1'b1 : tx_ph_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_clear   = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (bus.transmit) begin
                tx_shift_d = bus.tx_byte;
                tx_bit_d   = '0;
                tx_ph_d    = '0;
                tx_clear   = 1'b1;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = tx_bit_q + 1'b1;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 1'b1;
                if (tx_bit_q == TX_LAST_DATA) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_bit_q == TX_LAST_BIT) tx_state_d = TX_IDLE;
                else                         tx_bit_d   = tx_bit_q + 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_ph_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            is_tx_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_ph_q    <= tx_ph_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            is_tx_q    <= (tx_state_d != TX_IDLE);
        end
    end

    assign tx                  = tx_q;
    assign bus.received        = received_q;
    assign bus.rx_byte         = rx_byte_q;
    assign bus.is_receiving    = is_rx_q;
    assign bus.is_transmitting = is_tx_q;
    assign bus.recv_error      = recv_error_q;
endmodule

// File: tb/tb_uart_rn41.sv
// Directed bench for uart_rn41 at 50 MHz / 115200 baud (432 clks per bit).
module tb_uart_rn41;
    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic tx;

    uart_rn41_if bus_if ();

    uart_rn41 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .tx   (tx),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    localparam int BIT = 432;
    localparam int FRAME = 10 * BIT;
    localparam int ERR_BUSY = 4320;
`ifdef UART_RX_MAJORITY_EN
    localparam int RX_BUSY = 4131;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int RX_BUSY = 4104;
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         g_lo;
        int         g_hi;
        int         exp_rcv;
        int         exp_err;
        logic [7:0] exp_byte;
        int         exp_busy;
    } rx_vec_t;

    int n_pass = 0;
    int n_total = 0;
    int rcv_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (bus_if.received)   rcv_cnt++;
        if (bus_if.recv_error) err_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one rx frame plus 600 idle clks; optional forced-high window [g_lo, g_hi).
    task automatic send_rx(input logic [7:0] data, input logic stop,
                           input int g_lo, input int g_hi, output int busy);
        busy = 0;
        for (int c = 0; c < FRAME + 600; c++) begin
            int   b;
            logic v;
            b = c / BIT;
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = data[b-1];
            else if (b == 9) v = stop;
            else             v = 1'b1;
            if (c >= g_lo && c < g_hi) v = 1'b1;
            rx = v;
            if (bus_if.is_receiving) busy++;
            step();
        end
    endtask

    initial begin
        rx_vec_t    vecs[6];
        int         r0, e0, busy, tx_busy;
        logic [9:0] frame;

        vecs[0] = '{8'h01, 1'b1, -1, -1, 1, 0, 8'h01, RX_BUSY};
        vecs[1] = '{8'hA5, 1'b0, -1, -1, 0, 1, 8'h01, ERR_BUSY};
        vecs[2] = '{8'hFF, 1'b1, -1, -1, 1, 0, 8'hFF, RX_BUSY};
        vecs[3] = '{8'h80, 1'b1, -1, -1, 1, 0, 8'h80, RX_BUSY};
        vecs[4] = '{8'h00, 1'b1, 1931, 1958, 1, 0, GLITCH_EXP, RX_BUSY};
        vecs[5] = '{8'h5A, 1'b1, -1, -1, 1, 0, 8'h5A, RX_BUSY};

        rst_n = 1'b0;
        rx = 1'b1;
        bus_if.transmit = 1'b0;
        bus_if.tx_byte = 8'h00;
        repeat (3) step();
        check("reset_tx", int'(tx), 1);
        check("reset_rx_byte", int'(bus_if.rx_byte), 0);
        check("reset_flags", int'({bus_if.received, bus_if.is_receiving,
                                   bus_if.is_transmitting, bus_if.recv_error}), 0);
        rst_n = 1'b1;
        repeat (10) step();

        for (int i = 0; i < 6; i++) begin
            r0 = rcv_cnt;
            e0 = err_cnt;
            send_rx(vecs[i].data, vecs[i].stop, vecs[i].g_lo, vecs[i].g_hi, busy);
            check($sformatf("rx%0d_received", i), rcv_cnt - r0, vecs[i].exp_rcv);
            check($sformatf("rx%0d_recv_error", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("rx%0d_rx_byte", i), int'(bus_if.rx_byte), int'(vecs[i].exp_byte));
            check($sformatf("rx%0d_busy_clks", i), busy, vecs[i].exp_busy);
        end

        // Short low pulse: false start.
        r0 = rcv_cnt;
        e0 = err_cnt;
        for (int c = 0; c < 600; c++) begin
            rx = (c < 100) ? 1'b0 : 1'b1;
            if (c == 50)  check("false_start_busy", int'(bus_if.is_receiving), 1);
            if (c == 250) check("false_start_idle", int'(bus_if.is_receiving), 0);
            step();
        end
        check("false_start_received", rcv_cnt - r0, 0);
        check("false_start_error", err_cnt - e0, 0);

        // Transmit 0xA5; second request at clk 1000 must be ignored.
        frame = {1'b1, 8'hA5, 1'b0};
        tx_busy = 0;
        for (int c = 0; c < FRAME + 200; c++) begin
            bus_if.transmit = (c == 0 || c == 1000);
            bus_if.tx_byte  = (c == 1000) ? 8'h3C : ((c == 0) ? 8'hA5 : 8'h00);
            if (bus_if.is_transmitting) tx_busy++;
            if (c >= 217 && c < FRAME && (c - 217) % BIT == 0)
                check($sformatf("tx_bit%0d", (c - 217) / BIT), int'(tx), int'(frame[(c - 217) / BIT]));
            if (c == 432) check("tx_start_last_clk", int'(tx), 0);
            if (c == 433) check("tx_bit0_first_clk", int'(tx), 1);
            step();
        end
        bus_if.transmit = 1'b0;
        check("tx_busy_clks", tx_busy, 4320);
        check("tx_idle_high", int'(tx), 1);

        // Reset mid-RX (0x0F) and mid-TX (0x00).
        r0 = rcv_cnt;
        e0 = err_cnt;
        frame = {1'b1, 8'h0F, 1'b0};
        for (int c = 0; c < FRAME + 600; c++) begin
            rx = (c < FRAME) ? frame[c / BIT] : 1'b1;
            bus_if.transmit = (c == 0);
            bus_if.tx_byte  = 8'h00;
            if (c == 2299) begin
                check("pre_reset_rx_busy", int'(bus_if.is_receiving), 1);
                check("pre_reset_tx_busy", int'(bus_if.is_transmitting), 1);
            end
            if (c == 2300) begin
                rst_n = 1'b0;
                #1;
                check("async_reset_tx", int'(tx), 1);
                check("async_reset_flags", int'({bus_if.received, bus_if.is_receiving,
                                                 bus_if.is_transmitting, bus_if.recv_error}), 0);
                check("async_reset_rx_byte", int'(bus_if.rx_byte), 0);
            end
            if (c == 2400) rst_n = 1'b1;
            step();
        end
        check("reset_tail_received", rcv_cnt - r0, 0);
        check("reset_tail_error", err_cnt - e0, 0);
        r0 = rcv_cnt;
        send_rx(8'h06, 1'b1, -1, -1, busy);
        check("post_reset_received", rcv_cnt - r0, 1);
        check("post_reset_rx_byte", int'(bus_if.rx_byte), 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
